// File: rtl/centroid_finder.sv
// Foreground centroid of a thresholded frame in BRAM: raster scan, accumulate x/y/count, then 24-step restoring divide.
// Define CENTROID_BBOX_EN to add the foreground bounding-box outputs (bbox_left/right/top/bot).
module centroid_finder #(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int RAM_LATENCY = 1,
    parameter int MIN_COUNT   = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [15:0] pixel_data_in,
    output logic [16:0] addr_out,
    output logic        busy_out,
    output logic        data_valid_out,
    output logic [7:0]  x_center,
    output logic [8:0]  y_center,
    output logic [16:0] pixel_count_out,
    output logic        found_out
`ifdef CENTROID_BBOX_EN
    ,
    output logic [7:0]  bbox_left,
    output logic [7:0]  bbox_right,
    output logic [8:0]  bbox_top,
    output logic [8:0]  bbox_bot
`endif
);

    localparam logic [16:0] LAST_ADDR = 17'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0]  X_RST     = 8'(WIDTH / 2);
    localparam logic [8:0]  Y_RST     = 9'(HEIGHT / 2);
    localparam logic [4:0]  DRAIN_END = 5'(RAM_LATENCY - 1);
    localparam logic [4:0]  DIV_END   = 5'd23;
    localparam logic [16:0] MIN_CNT   = 17'(MIN_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DIVIDE, S_DONE} state_t;

    state_t      state_q;
    logic [16:0] addr_q;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [4:0]  step_q;
    logic        busy_q, dv_q, found_q;
    logic [7:0]  xc_q;
    logic [8:0]  yc_q;
    logic [16:0] cnt_out_q;

    // sum_*_q double as the divider dividends; quotient bits shift in at the LSB
    logic [23:0] sum_x_q, sum_y_q;
    logic [16:0] count_q;
    logic [16:0] rem_x_q, rem_y_q;

    logic [RAM_LATENCY-1:0]       vld_pipe_q;
    logic [RAM_LATENCY-1:0][7:0]  x_pipe_q;
    logic [RAM_LATENCY-1:0][8:0]  y_pipe_q;

`ifdef CENTROID_BBOX_EN
    logic [7:0] min_x_q, max_x_q, bl_q, br_q;
    logic [8:0] min_y_q, max_y_q, bt_q, bb_q;
`endif

    // Delay x/y by the BRAM latency so they line up with pixel_data_in
    always_ff @(posedge clk_in) begin
        x_pipe_q[0] <= x_q;
        y_pipe_q[0] <= y_q;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            x_pipe_q[i] <= x_pipe_q[i-1];
            y_pipe_q[i] <= y_pipe_q[i-1];
        end
        if (!rst_in) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= (state_q == S_SCAN);
            for (int i = 1; i < RAM_LATENCY; i++)
                vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    logic       acc_hit;
    logic [7:0] acc_x;
    logic [8:0] acc_y;
    assign acc_hit = vld_pipe_q[RAM_LATENCY-1] && (pixel_data_in != 16'd0);
    assign acc_x   = x_pipe_q[RAM_LATENCY-1];
    assign acc_y   = y_pipe_q[RAM_LATENCY-1];

    logic [17:0] rx_sh, ry_sh;
    logic        qx, qy;
    logic [16:0] rem_x_d, rem_y_d;
    logic [7:0]  quo_x_lo;
    logic [8:0]  quo_y_lo;

    always_comb begin
        rx_sh    = {rem_x_q, sum_x_q[23]};
        ry_sh    = {rem_y_q, sum_y_q[23]};
        qx       = rx_sh >= {1'b0, count_q};
        qy       = ry_sh >= {1'b0, count_q};
        rem_x_d  = qx ? 17'(rx_sh - {1'b0, count_q}) : rx_sh[16:0];
        rem_y_d  = qy ? 17'(ry_sh - {1'b0, count_q}) : ry_sh[16:0];
        quo_x_lo = {sum_x_q[6:0], qx};
        quo_y_lo = {sum_y_q[7:0], qy};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
            xc_q      <= X_RST;
            yc_q      <= Y_RST;
            cnt_out_q <= '0;
            found_q   <= 1'b0;
            step_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
`ifdef CENTROID_BBOX_EN
            bl_q <= '0;
            br_q <= '0;
            bt_q <= '0;
            bb_q <= '0;
`endif
        end else begin
            dv_q <= 1'b0;
            if (acc_hit) begin
                sum_x_q <= sum_x_q + 24'(acc_x);
                sum_y_q <= sum_y_q + 24'(acc_y);
                count_q <= count_q + 17'd1;
`ifdef CENTROID_BBOX_EN
                if (acc_x < min_x_q) min_x_q <= acc_x;
                if (acc_x > max_x_q) max_x_q <= acc_x;
                if (acc_y < min_y_q) min_y_q <= acc_y;
                if (acc_y > max_y_q) max_y_q <= acc_y;
`endif
            end
            case (state_q)
                S_IDLE: begin
                    addr_q <= '0;
                    if (start_in) begin
                        sum_x_q <= '0;
                        sum_y_q <= '0;
                        count_q <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
`ifdef CENTROID_BBOX_EN
                        min_x_q <= '1;
                        max_x_q <= '0;
                        min_y_q <= '1;
                        max_y_q <= '0;
`endif
                    end
                end
                S_SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        step_q  <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + 17'd1;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 9'd1;
                        end else begin
                            x_q <= x_q + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (step_q == DRAIN_END) begin
                        step_q  <= '0;
                        addr_q  <= '0;
                        rem_x_q <= '0;
                        rem_y_q <= '0;
                        state_q <= S_DIVIDE;
                    end else begin
                        step_q <= step_q + 5'd1;
                    end
                end
                S_DIVIDE: begin
                    sum_x_q <= {sum_x_q[22:0], qx};
                    sum_y_q <= {sum_y_q[22:0], qy};
                    rem_x_q <= rem_x_d;
                    rem_y_q <= rem_y_d;
                    if (step_q == DIV_END) begin
                        // Final quotient bit is folded in here so results land with the strobe
                        dv_q      <= 1'b1;
                        cnt_out_q <= count_q;
                        state_q   <= S_DONE;
                        if (count_q == 17'd0) begin
                            xc_q    <= X_RST;
                            yc_q    <= Y_RST;
                            found_q <= 1'b0;
                        end else begin
                            xc_q    <= quo_x_lo;
                            yc_q    <= quo_y_lo;
                            found_q <= count_q >= MIN_CNT;
                        end
`ifdef CENTROID_BBOX_EN
                        if (count_q == 17'd0) begin
                            bl_q <= '0;
                            br_q <= '0;
                            bt_q <= '0;
                            bb_q <= '0;
                        end else begin
                            bl_q <= min_x_q;
                            br_q <= max_x_q;
                            bt_q <= min_y_q;
                            bb_q <= max_y_q;
                        end
`endif
                    end else begin
                        step_q <= step_q + 5'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_out        = addr_q;
    assign busy_out        = busy_q;
    assign data_valid_out  = dv_q;
    assign x_center        = xc_q;
    assign y_center        = yc_q;
    assign pixel_count_out = cnt_out_q;
    assign found_out       = found_q;
`ifdef CENTROID_BBOX_EN
    assign bbox_left  = bl_q;
    assign bbox_right = br_q;
    assign bbox_top   = bt_q;
    assign bbox_bot   = bb_q;
`endif

endmodule

// File: tb/tb_centroid_finder.sv
// Directed bench for centroid_finder on a reduced 40x48 frame; BRAM modelled as a 1-cycle function of address.
module tb_centroid_finder;
    localparam int W    = 40;
    localparam int H    = 48;
    localparam int NPIX = W * H;
    localparam int LAT  = 1 + NPIX + 1 + 24;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [15:0] pixel_data_in;
    logic [16:0] addr_out;
    logic        busy_out, data_valid_out, found_out;
    logic [7:0]  x_center;
    logic [8:0]  y_center;
    logic [16:0] pixel_count_out;
`ifdef CENTROID_BBOX_EN
    logic [7:0]  bbox_left, bbox_right;
    logic [8:0]  bbox_top, bbox_bot;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int mode   = 0;

    centroid_finder #(.WIDTH(W), .HEIGHT(H), .RAM_LATENCY(1), .MIN_COUNT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .pixel_data_in(pixel_data_in), .addr_out(addr_out),
        .busy_out(busy_out), .data_valid_out(data_valid_out),
        .x_center(x_center), .y_center(y_center),
        .pixel_count_out(pixel_count_out), .found_out(found_out)
`ifdef CENTROID_BBOX_EN
        , .bbox_left(bbox_left), .bbox_right(bbox_right),
        .bbox_top(bbox_top), .bbox_bot(bbox_bot)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] pix(input int m, input int a);
        int x, y;
        x = a % W;
        y = a / W;
        case (m)
            1: return (a == 20 * W + 10) ? 16'h0001 : 16'h0000;
            2: return (x >= 10 && x <= 29 && y >= 14 && y <= 33) ? 16'h8000 : 16'h0000;
            3: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk_in) pixel_data_in <= pix(mode, int'(addr_out));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_dv"}, data_valid_out, 0);
        chk({tag, "_addr"}, addr_out, 0);
        chk({tag, "_x"}, x_center, W / 2);
        chk({tag, "_y"}, y_center, H / 2);
        chk({tag, "_cnt"}, pixel_count_out, 0);
        chk({tag, "_found"}, found_out, 0);
`ifdef CENTROID_BBOX_EN
        chk({tag, "_bbox"}, {bbox_left, bbox_right, bbox_top, bbox_bot}, 0);
`endif
    endtask

    // Runs one frame; extra_at injects a second start pulse that many cycles after the accepted one.
    task automatic run_frame(input string tag, input int m, input int ex, input int ey,
                             input int ecnt, input int efound, input int ebl, input int ebr,
                             input int ebt, input int ebb, input int extra_at);
        int n, bad, idle_bad;
        mode = m;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        chk({tag, "_busy_start"}, busy_out, 1);
        n = 1;
        bad = 0;
        while (!data_valid_out && n < 4000) begin
            if (n <= NPIX + 1 && int'(addr_out) != ((n <= NPIX) ? n - 1 : NPIX - 1)) bad++;
            start_in = (n == extra_at);
            @(negedge clk_in);
            n++;
        end
        start_in = 1'b0;
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_addr_seq"}, bad, 0);
        chk({tag, "_busy_done"}, busy_out, 1);
        chk({tag, "_x"}, x_center, ex);
        chk({tag, "_y"}, y_center, ey);
        chk({tag, "_cnt"}, pixel_count_out, ecnt);
        chk({tag, "_found"}, found_out, efound);
`ifdef CENTROID_BBOX_EN
        chk({tag, "_bbox_l"}, bbox_left, ebl);
        chk({tag, "_bbox_r"}, bbox_right, ebr);
        chk({tag, "_bbox_t"}, bbox_top, ebt);
        chk({tag, "_bbox_b"}, bbox_bot, ebb);
`endif
        idle_bad = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (busy_out || data_valid_out) idle_bad++;
        end
        chk({tag, "_idle_after"}, idle_bad, 0);
        chk({tag, "_x_hold"}, x_center, ex);
    endtask

    initial begin
        rst_in   = 1'b0;
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_reset_state("rst");
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        run_frame("zero",   0, W / 2, H / 2, 0, 0, 0, 0, 0, 0, -1);
        run_frame("single", 1, 10, 20, 1, 1, 10, 10, 20, 20, -1);
        run_frame("rect",   2, 19, 23, 400, 1, 10, 29, 14, 33, 1000);
        run_frame("full",   3, 19, 23, NPIX, 1, 0, W - 1, 0, H - 1, -1);

        // Reset mid-scan, with start held high on the reset edge
        mode = 2;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        repeat (500) @(negedge clk_in);
        rst_in = 1'b0;
        start_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        start_in = 1'b0;
        chk_reset_state("midrst");
        repeat (3) @(negedge clk_in);
        chk("midrst_stays_idle", busy_out, 0);
        run_frame("after_rst", 1, 10, 20, 1, 1, 10, 10, 20, 20, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
